// File: rtl/axis_pattern_gen.sv
// AXI4-Stream test-packet source: counter / walking-one / LFSR / constant patterns.
// Define AXIS_GEN_HDR_EN to replace beat 0 of each packet with a header word.
module axis_pattern_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PKT_LEN    = 16,
  parameter int unsigned NUM_PKTS   = 0,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001,
  parameter logic [31:0] CONST_VAL  = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           pkt_count,
  output logic                  done
);

  localparam int unsigned IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned WALK_W   = $clog2(DATA_WIDTH);
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef AXIS_GEN_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic [1:0]            r_state, w_state_nxt;
  logic [1:0]            r_mode, w_mode_nxt;
  logic [IDX_W-1:0]      r_beat_idx, w_idx_nxt;
  logic [WALK_W-1:0]     r_walk, w_walk_nxt;
  logic [DATA_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]           r_lfsr, w_lfsr_nxt;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_nxt;
  logic [15:0]           r_pkt_count, w_pc_nxt;
  logic                  r_tvalid, w_tvalid_nxt;
  logic                  r_tlast, w_tlast_nxt;
  logic [DATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_start;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_pat_beat;

  function automatic logic [DATA_WIDTH-1:0] f_pattern(
    input logic [1:0]            m,
    input logic [DATA_WIDTH-1:0] cnt,
    input logic [31:0]           lfsr,
    input logic [WALK_W-1:0]     walk
  );
    case (m)
      2'd0:    return cnt;
      2'd1:    return DATA_WIDTH'(1'b1) << walk;
      2'd2:    return DATA_WIDTH'(lfsr);
      default: return DATA_WIDTH'(CONST_VAL);
    endcase
  endfunction

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting left
  function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign w_beat     = r_tvalid && m_axis_tready;
  assign w_last     = (r_beat_idx == LAST_IDX);
  assign w_pat_beat = !(HDR_EN && (r_beat_idx == '0));

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_idx_nxt    = r_beat_idx;
    w_walk_nxt   = r_walk;
    w_cnt_nxt    = r_cnt;
    w_lfsr_nxt   = r_lfsr;
    w_gap_nxt    = r_gap_cnt;
    w_pc_nxt     = r_pkt_count;
    w_tvalid_nxt = r_tvalid;
    w_tlast_nxt  = r_tlast;
    w_tdata_nxt  = r_tdata;
    w_done_nxt   = r_done;
    w_start      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tvalid_nxt = 1'b0;
        w_tlast_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        if (enable) begin
          w_pc_nxt   = '0;
          w_lfsr_nxt = LFSR_SEED;
          w_start    = 1'b1;
        end
      end
      S_SEND: begin
        if (w_beat) begin
          if (w_pat_beat) begin
            w_cnt_nxt  = r_cnt + DATA_WIDTH'(1);
            w_lfsr_nxt = f_lfsr_step(r_lfsr);
            w_walk_nxt = (r_walk == WALK_W'(DATA_WIDTH - 1)) ? '0 : r_walk + WALK_W'(1);
          end
          if (w_last) begin
            w_pc_nxt     = r_pkt_count + 16'd1;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            if ((NUM_PKTS != 0) && (w_pc_nxt == 16'(NUM_PKTS))) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = GAP_W'(GAP_LOAD);
            end else if (enable) begin
              w_start = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt   = r_beat_idx + IDX_W'(1);
            w_tdata_nxt = f_pattern(r_mode, w_cnt_nxt, w_lfsr_nxt, w_walk_nxt);
            w_tlast_nxt = (w_idx_nxt == LAST_IDX);
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (enable) w_start = 1'b1;
          else        w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        w_tvalid_nxt = 1'b0;
        if (!enable) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Packet start: mode is sampled here and only here
    if (w_start) begin
      w_state_nxt  = S_SEND;
      w_mode_nxt   = mode;
      w_idx_nxt    = '0;
      w_walk_nxt   = '0;
      w_tvalid_nxt = 1'b1;
      w_tlast_nxt  = (PKT_LEN == 1);
      w_tdata_nxt  = f_pattern(mode, w_cnt_nxt, w_lfsr_nxt, '0);
`ifdef AXIS_GEN_HDR_EN
      w_tdata_nxt  = DATA_WIDTH'({8'hA5, 6'd0, mode, w_pc_nxt});
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_beat_idx  <= '0;
      r_walk      <= '0;
      r_cnt       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_gap_cnt   <= '0;
      r_pkt_count <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tdata     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_beat_idx  <= w_idx_nxt;
      r_walk      <= w_walk_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_pkt_count <= w_pc_nxt;
      r_tvalid    <= w_tvalid_nxt;
      r_tlast     <= w_tlast_nxt;
      r_tdata     <= w_tdata_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign pkt_count     = r_pkt_count;
  assign done          = r_done;

endmodule
